// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters: grant, register operands, capture result.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [16*NREQ-1:0] req_a,
    input  logic [16*NREQ-1:0] req_b,
    input  logic [4*NREQ-1:0] req_ctl,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_y,
    output logic              rsp_z,
    output logic              rsp_sign,
    output logic [15:0]       alu_a,
    output logic [15:0]       alu_b,
    output logic [3:0]        alu_ctl,
    input  logic [15:0]       alu_y,
    input  logic              alu_z,
    input  logic              alu_sign,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state;
    state_t         next_state;
    logic [IDW-1:0] win;
    logic           any_req;
    logic [IDW-1:0] pend_id;
    logic           grant;

`ifdef ALU_ARB_RR_EN
    logic [IDW-1:0] rr_ptr;

    // Search from the slot after the last grant; descending k lets the nearest candidate win.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if ((req_valid & (NREQ'(1) << ((int'(rr_ptr) + k) % NREQ))) != '0) begin
                win     = IDW'((int'(rr_ptr) + k) % NREQ);
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= IDW'(NREQ - 1);
        else if (grant)
            rr_ptr <= win;
    end
`else
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if ((req_valid & (NREQ'(1) << i)) != '0) begin
                win     = IDW'(i);
                any_req = 1'b1;
            end
        end
    end
`endif

    assign grant     = (state == IDLE) && any_req;
    assign req_ready = grant ? (NREQ'(1) << win) : '0;
    assign busy      = (state != IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = EXEC;
            EXEC:    next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_ctl <= '0;
            pend_id <= '0;
        end else if (grant) begin
            alu_a   <= req_a[16*win +: 16];
            alu_b   <= req_b[16*win +: 16];
            alu_ctl <= req_ctl[4*win +: 4];
            pend_id <= win;
        end
    end

    // The ALU result is captured at the end of EXEC and held until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
            rsp_z     <= 1'b0;
            rsp_sign  <= 1'b0;
        end else if (state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= pend_id;
            rsp_y     <= alu_y;
            rsp_z     <= alu_z;
            rsp_sign  <= alu_sign;
        end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a stub ALU: ctl 0 adds, ctl 6 subtracts, others XOR.
// Contention expectations follow ALU_ARB_RR_EN when it is defined.
module tb_alu_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [16*NREQ-1:0] req_a = '0;
    logic [16*NREQ-1:0] req_b = '0;
    logic [4*NREQ-1:0] req_ctl = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_y;
    logic              rsp_z;
    logic              rsp_sign;
    logic [15:0]       alu_a;
    logic [15:0]       alu_b;
    logic [3:0]        alu_ctl;
    logic [15:0]       alu_y;
    logic              alu_z;
    logic              alu_sign;
    logic              busy;

    typedef struct {
        int          id;
        logic [15:0] y;
        logic        z;
        logic        sign;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctl(req_ctl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_z(rsp_z), .rsp_sign(rsp_sign),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
        .alu_y(alu_y), .alu_z(alu_z), .alu_sign(alu_sign),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Stub ALU standing in for the real combinational unit.
    always_comb begin
        case (alu_ctl)
            4'd0:    alu_y = alu_a + alu_b;
            4'd6:    alu_y = alu_a - alu_b;
            default: alu_y = alu_a ^ alu_b;
        endcase
        alu_z    = (alu_y == 16'd0);
        alu_sign = alu_y[15];
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Responses are checked on the cycle the consumer accepts them.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL unexpected_rsp: got id=%0d y=%0h, expected none", rsp_id, rsp_y);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("rsp_id",   32'(rsp_id),   32'(e.id));
                check_output("rsp_y",    32'(rsp_y),    32'(e.y));
                check_output("rsp_z",    32'(rsp_z),    32'(e.z));
                check_output("rsp_sign", 32'(rsp_sign), 32'(e.sign));
            end
        end
    end

    // Entered and left just after a rising edge; presents one request and waits for its grant.
    task automatic apply_stimulus(input int id, input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] ctl, input bit push, input logic [15:0] ey,
                                  input logic ez, input logic es, output int waited);
        exp_t e;
        req_a[16*id +: 16]  = a;
        req_b[16*id +: 16]  = b;
        req_ctl[4*id +: 4]  = ctl;
        req_valid[id]       = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!req_ready[id] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready[id]) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL grant_timeout: got no grant for req %0d, expected grant", id);
        end else if (push) begin
            e.id = id; e.y = ey; e.z = ez; e.sign = es;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        check_output("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   w;
        int   gid;
        int   last_cyc;
        int   exp_seq[4];
        exp_t e;

        // Reset values
        #3;
        check_output("rst_req_ready", 32'(req_ready), 32'd0);
        check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("rst_busy",      32'(busy),      32'd0);
        check_output("rst_alu_a",     32'(alu_a),     32'd0);
        check_output("rst_rsp_y",     32'(rsp_y),     32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single op: same-cycle grant, response two edges later
        rsp_ready = 1'b1;
        apply_stimulus(0, 16'd25, 16'd25, 4'd0, 1'b1, 16'd50, 1'b0, 1'b0, w);
        check_output("single_grant_wait", 32'(w), 32'd0);
        @(negedge clk);
        check_output("single_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("single_exec_busy",      32'(busy),      32'd1);
        @(negedge clk);
        check_output("single_rsp_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // Backpressure: hold rsp_ready low with a second request pending
        rsp_ready = 1'b0;
        apply_stimulus(1, 16'd25, 16'd25, 4'd6, 1'b1, 16'd0, 1'b1, 1'b0, w);
        req_a[15:0] = 16'd100; req_b[15:0] = 16'd7; req_ctl[3:0] = 4'd0;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_output("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check_output("bp_rsp_y",     32'(rsp_y),     32'd0);
            check_output("bp_rsp_z",     32'(rsp_z),     32'd1);
            check_output("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        check_output("bp_accept_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_output("bp_next_grant", 32'(req_ready), 32'b01);
        e.id = 0; e.y = 16'd107; e.z = 1'b0; e.sign = 1'b0;
        if (req_ready[0]) exp_q.push_back(e);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        drain();

        // Negative operand from requester 1
        apply_stimulus(1, 16'hFFF6, 16'd25, 4'd6, 1'b1, 16'hFFDD, 1'b0, 1'b1, w);
        drain();

        // Contention with both requesters held valid
        req_a = {16'd5, 16'd1}; req_b = {16'd3, 16'd2}; req_ctl = {4'd6, 4'd0};
        req_valid = 2'b11;
`ifdef ALU_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        last_cyc = 0;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            for (int t = 0; t < 20 && req_ready == '0; t++) @(negedge clk);
            gid = req_ready[1] ? 1 : 0;
            check_output("cont_grant_id", 32'(gid), 32'(exp_seq[g]));
            if (g > 0) check_output("cont_spacing", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            e.id = gid; e.y = (gid == 1) ? 16'd2 : 16'd3; e.z = 1'b0; e.sign = 1'b0;
            if (req_ready != '0) exp_q.push_back(e);
            @(posedge clk);
        end
        #1 req_valid = '0;
        drain();

        // Reset during EXEC discards the operation
        apply_stimulus(0, 16'd3, 16'd4, 4'd0, 1'b0, 16'd0, 1'b0, 1'b0, w);
        #2 rst = 1'b1;
        #1;
        check_output("mid_rst_busy",      32'(busy),      32'd0);
        check_output("mid_rst_alu_a",     32'(alu_a),     32'd0);
        check_output("mid_rst_alu_b",     32'(alu_b),     32'd0);
        check_output("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("mid_rst_rsp_y",     32'(rsp_y),     32'd0);
        check_output("mid_rst_rsp_id",    32'(rsp_id),    32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        apply_stimulus(0, 16'd3, 16'd4, 4'd0, 1'b1, 16'd7, 1'b0, 1'b0, w);
        drain();

        // Idle: nothing granted, ALU operands hold
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("idle_req_ready", 32'(req_ready), 32'd0);
            check_output("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            check_output("idle_busy",      32'(busy),      32'd0);
            check_output("idle_alu_a",     32'(alu_a),     32'd3);
            check_output("idle_alu_b",     32'(alu_b),     32'd4);
            check_output("idle_alu_ctl",   32'(alu_ctl),   32'd0);
        end

        check_output("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares the single combinational 16-bit `alu` (ports a, b, ctl, y, z, sign) between NREQ requesters.
- Each requester presents operands and a 4-bit ctl code over a valid/ready handshake.
- The block grants one requester at a time, drives the ALU from registered operands, and captures y/z/sign into a response register tagged with the requester index.
- It sits between the decode/issue units and the ALU instance, so the ALU itself stays purely combinational.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8)
- IDW, 1, width of requester index (ceil(log2(NREQ)), minimum 1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant; at most one bit high
- req_a  in  16*NREQ  operand a, requester i at bits [16i+15:16i]
- req_b  in  16*NREQ  operand b, same packing
- req_ctl  in  4*NREQ  ALU ctl code, requester i at bits [4i+3:4i]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_id  out  IDW  index of requester owning the response
- rsp_y  out  16  captured ALU y
- rsp_z  out  1  captured ALU z
- rsp_sign  out  1  captured ALU sign
- alu_a  out  16  to ALU a (registered)
- alu_b  out  16  to ALU b (registered)
- alu_ctl  out  4  to ALU ctl (registered)
- alu_y  in  16  from ALU y
- alu_z  in  1  from ALU z
- alu_sign  in  1  from ALU sign
- busy  out  1  high in EXEC or RESP

## Operation
FSM states: IDLE, EXEC, RESP. Reset state is IDLE.

- **IDLE:**
  - If any req_valid is set, the arbiter selects winner w and drives req_ready[w]=1 combinationally.
  - On that edge, req_a/b/ctl of w are loaded into alu_a/b/ctl, w is stored as the pending id, and the FSM goes to EXEC.
  - With no valid request, stay in IDLE; all req_ready are 0.
- **EXEC:**
  - The ALU settles from the registered operands.
  - On the edge, alu_y/z/sign go to rsp_y/z/sign, the pending id goes to rsp_id, rsp_valid is set, and the FSM goes to RESP.
- **RESP:**
  - rsp_valid is held with stable rsp_* until rsp_ready=1.
  - On the edge where rsp_valid & rsp_ready, clear rsp_valid and go to IDLE.
  - No grants are issued in EXEC or RESP.
- **Requester rules:**
  - Once req_valid[i] rises, the requester holds it and its operands stable until req_ready[i]. The block does not tolerate withdrawal.
  - req_ready is never high outside IDLE.
- **Data handling:**
  - ctl is passed through unmodified; the block does not interpret ALU codes.
  - No arithmetic in the block; all widths pass through 1:1.
- **Async reset:**
  - Forces IDLE and clears every register.
  - An in-flight operation is discarded with no response.
  - Requesters must re-present after reset.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_z=0, rsp_sign=0
  - alu_a=0, alu_b=0, alu_ctl=0, busy=0
  - round-robin pointer = NREQ-1, so requester 0 has first priority
- Handshake at edge T (req_valid & req_ready): rsp_valid rises after edge T+1, with 2-cycle latency.
- With rsp_ready held high, the earliest next grant is at edge T+3.
- Peak throughput is one operation per 3 cycles.
- rsp_* are registered; the ALU combinational path is contained within the EXEC cycle.

## Configuration
- With `ALU_ARB_RR_EN` defined: round-robin arbitration.
  - The search starts at (last granted index + 1) mod NREQ.
  - The pointer updates only on a grant.
  - A continuously requesting requester waits at most NREQ-1 grants.
- Without it: fixed priority, lowest index wins; the pointer register is not implemented.

## Test plan
- **Single op:** requester 0 presents a=25, b=25, ctl=0.
  - req_ready[0] goes high in the same cycle.
  - rsp_valid rises two edges later with rsp_id=0, and rsp_y/z/sign equal the alu outputs for (25,25,0).
- **Response backpressure:** rsp_ready held 0 for 5 cycles.
  - rsp_valid and rsp_y stay stable; no req_ready is asserted despite pending requests.
  - A grant is issued the cycle after rsp_ready is taken.
- **Contention:** requesters 0 and 1 are valid continuously with rsp_ready=1.
  - With `ALU_ARB_RR_EN`, grants alternate 0,1,0,1 at 3-cycle spacing.
  - Without it, only 0 is granted while its valid stays high.
- **Negative operand:** requester 1 presents a=-10 (16'hFFF6), b=25, ctl=6.
  - rsp_id=1, and rsp_sign/z equal the alu outputs for those inputs.
- **Reset mid-operation:** assert rst during EXEC.
  - All outputs go to 0 immediately without waiting for clk, and no response is emitted.
  - After release, a re-presented request completes normally.
- **Idle:** all req_valid=0 for 10 cycles.
  - req_ready, rsp_valid and busy stay 0, and alu_a/b/ctl hold their previous values.
